// File: rtl/exec_writeback_if.sv
// exec_writeback_if: ALU-result, register-file write, flag, redirect and forwarding signals of the
// execute/writeback stage, with master (upstream/env) and slave (stage) views.
interface exec_writeback_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4,
    parameter int PC_W    = 24
);
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_result;
    logic               in_cout;
    logic               in_vout;
    logic               in_djtaken;
    logic               in_is_dj;
    logic [PC_W-1:0]    in_target;
    logic               in_wen;
    logic [RADDR_W-1:0] in_waddr;
    logic               in_flags_we;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic               rf_ready;
    logic               psr_c;
    logic               psr_v;
    logic               psr_z;
    logic               psr_s;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic [RADDR_W-1:0] fwd_raddr;
    logic               fwd_hit;
    logic [DATA_W-1:0]  fwd_data;

    modport master (
        output in_valid, in_result, in_cout, in_vout, in_djtaken, in_is_dj, in_target,
               in_wen, in_waddr, in_flags_we, rf_ready, fwd_raddr,
        input  in_ready, rf_we, rf_waddr, rf_wdata, psr_c, psr_v, psr_z, psr_s,
               redirect_valid, redirect_pc, fwd_hit, fwd_data
    );

    modport slave (
        input  in_valid, in_result, in_cout, in_vout, in_djtaken, in_is_dj, in_target,
               in_wen, in_waddr, in_flags_we, rf_ready, fwd_raddr,
        output in_ready, rf_we, rf_waddr, rf_wdata, psr_c, psr_v, psr_z, psr_s,
               redirect_valid, redirect_pc, fwd_hit, fwd_data
    );
endinterface

// File: rtl/exec_writeback.sv
// exec_writeback: 2-entry skid buffer from ALU to register-file write port, status flags,
// DJ* branch redirect and forwarding of pending register writes.
module exec_writeback #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4,
    parameter int PC_W    = 24
) (
    input logic              clk,
    input logic              reset_b,
    exec_writeback_if.slave  wb
);
    // Entry 0 is always the head; entry 1 is only valid when entry 0 is.
    logic [1:0]                 v_q, v_d;
    logic [1:0][RADDR_W-1:0]    a_q, a_d;
    logic [1:0][DATA_W-1:0]     d_q, d_d;
    logic [3:0]                 psr_q, psr_d;
    logic                       redir_q, redir_d;
    logic [PC_W-1:0]            pc_q, pc_d;
    logic                       accept, push, pop;

    assign wb.in_ready = !v_q[1] && !redir_q;
    assign accept      = wb.in_valid && wb.in_ready;
    assign push        = accept && wb.in_wen;
    assign pop         = v_q[0] && wb.rf_ready;

    always_comb begin
        v_d = v_q;
        a_d = a_q;
        d_d = d_q;
        if (pop) begin
            v_d[0] = v_q[1];
            a_d[0] = a_q[1];
            d_d[0] = d_q[1];
            v_d[1] = 1'b0;
        end
        if (push) begin
            if (v_d[0]) begin
                v_d[1] = 1'b1;
                a_d[1] = wb.in_waddr;
                d_d[1] = wb.in_result;
            end else begin
                v_d[0] = 1'b1;
                a_d[0] = wb.in_waddr;
                d_d[0] = wb.in_result;
            end
        end
    end

    always_comb begin
        psr_d   = (accept && wb.in_flags_we)
                ? {wb.in_cout, wb.in_vout, wb.in_result == '0, wb.in_result[DATA_W-1]} : psr_q;
        redir_d = accept && wb.in_is_dj && wb.in_djtaken;
        pc_d    = redir_d ? wb.in_target : pc_q;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            v_q     <= '0;
            a_q     <= '0;
            d_q     <= '0;
            psr_q   <= '0;
            redir_q <= 1'b0;
            pc_q    <= '0;
        end else begin
            v_q     <= v_d;
            a_q     <= a_d;
            d_q     <= d_d;
            psr_q   <= psr_d;
            redir_q <= redir_d;
            pc_q    <= pc_d;
        end
    end

    assign wb.rf_we          = v_q[0];
    assign wb.rf_waddr       = a_q[0];
    assign wb.rf_wdata       = d_q[0];
    assign {wb.psr_c, wb.psr_v, wb.psr_z, wb.psr_s} = psr_q;
    assign wb.redirect_valid = redir_q;
    assign wb.redirect_pc    = pc_q;

    // Youngest pending write wins.
    always_comb begin
        wb.fwd_hit  = 1'b0;
        wb.fwd_data = '0;
        if (v_q[1] && a_q[1] == wb.fwd_raddr) begin
            wb.fwd_hit  = 1'b1;
            wb.fwd_data = d_q[1];
        end else if (v_q[0] && a_q[0] == wb.fwd_raddr) begin
            wb.fwd_hit  = 1'b1;
            wb.fwd_data = d_q[0];
        end
    end
endmodule

// File: tb/tb_exec_writeback.sv
// tb_exec_writeback: directed vectors with hand-computed expectations for exec_writeback.
module tb_exec_writeback;
    logic clk = 1'b0;
    logic reset_b = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    exec_writeback_if #(.DATA_W(32), .RADDR_W(4), .PC_W(24)) wb ();
    exec_writeback #(.DATA_W(32), .RADDR_W(4), .PC_W(24)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .wb      (wb.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb.in_valid    = 1'b0;
        wb.in_result   = '0;
        wb.in_cout     = 1'b0;
        wb.in_vout     = 1'b0;
        wb.in_djtaken  = 1'b0;
        wb.in_is_dj    = 1'b0;
        wb.in_target   = '0;
        wb.in_wen      = 1'b0;
        wb.in_waddr    = '0;
        wb.in_flags_we = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        idle();
        wb.in_valid  = 1'b1;
        wb.in_wen    = 1'b1;
        wb.in_waddr  = a;
        wb.in_result = d;
    endtask

    function automatic logic [3:0] psr();
        return {wb.psr_c, wb.psr_v, wb.psr_z, wb.psr_s};
    endfunction

    initial begin
        idle();
        wb.rf_ready  = 1'b0;
        wb.fwd_raddr = '0;
        tick();
        tick();
        check("rst_rf_we", 32'(wb.rf_we), 32'd0);
        check("rst_in_ready", 32'(wb.in_ready), 32'd1);
        check("rst_psr", 32'(psr()), 32'h0);
        check("rst_redir", 32'(wb.redirect_valid), 32'd0);
        check("rst_redir_pc", 32'(wb.redirect_pc), 32'd0);
        reset_b = 1'b1;

        // 0x7FFFFFFF + 1 = 0x80000000: V=1, S=1, C=0, Z=0
        wr(4'd3, 32'h8000_0000);
        wb.in_vout     = 1'b1;
        wb.in_flags_we = 1'b1;
        tick();
        idle();
        check("add_psr", 32'(psr()), 32'b0101);
        check("add_rf_we", 32'(wb.rf_we), 32'd1);
        check("add_waddr", 32'(wb.rf_waddr), 32'd3);
        check("add_wdata", wb.rf_wdata, 32'h8000_0000);
        wb.rf_ready = 1'b1;
        tick();
        check("add_retired", 32'(wb.rf_we), 32'd0);

        // Fill buffer while write port is busy
        wb.rf_ready = 1'b0;
        wr(4'd1, 32'h11);
        tick();
        wr(4'd2, 32'h22);
        tick();
        idle();
        check("full_ready", 32'(wb.in_ready), 32'd0);
        check("full_head_a", 32'(wb.rf_waddr), 32'd1);
        check("full_head_d", wb.rf_wdata, 32'h11);
        check("flags_hold", 32'(psr()), 32'b0101);
        wb.rf_ready = 1'b1;
        #1;
        check("full_no_bypass", 32'(wb.in_ready), 32'd0);
        tick();
        check("order2_a", 32'(wb.rf_waddr), 32'd2);
        check("order2_d", wb.rf_wdata, 32'h22);
        check("order2_we", 32'(wb.rf_we), 32'd1);
        check("ready_back", 32'(wb.in_ready), 32'd1);
        tick();
        check("drained", 32'(wb.rf_we), 32'd0);

        // Forwarding: youngest match wins
        wb.rf_ready = 1'b0;
        wr(4'd5, 32'hA);
        tick();
        wr(4'd5, 32'hB);
        tick();
        idle();
        wb.fwd_raddr = 4'd5;
        #1;
        check("fwd_hit5", 32'(wb.fwd_hit), 32'd1);
        check("fwd_data5", wb.fwd_data, 32'hB);
        wb.fwd_raddr = 4'd6;
        #1;
        check("fwd_hit6", 32'(wb.fwd_hit), 32'd0);
        check("fwd_data6", wb.fwd_data, 32'h0);
        wb.rf_ready = 1'b1;
        wb.fwd_raddr = 4'd5;
        tick();
        check("fwd_after_pop", wb.fwd_data, 32'hB);
        tick();
        check("fwd_empty", 32'(wb.fwd_hit), 32'd0);

        // Asynchronous reset with two pending writes
        wb.rf_ready = 1'b0;
        wr(4'd8, 32'h88);
        tick();
        wr(4'd9, 32'h99);
        tick();
        idle();
        check("pre_rst_full", 32'(wb.in_ready), 32'd0);
        #2;
        reset_b = 1'b0;
        #1;
        check("mid_rst_we", 32'(wb.rf_we), 32'd0);
        check("mid_rst_ready", 32'(wb.in_ready), 32'd1);
        check("mid_rst_psr", 32'(psr()), 32'h0);
        tick();
        reset_b = 1'b1;
        wb.rf_ready = 1'b1;
        tick();
        check("post_rst_we", 32'(wb.rf_we), 32'd0);
        check("post_rst_redir", 32'(wb.redirect_valid), 32'd0);

        // Taken DJNZ; fall-through offered during the redirect cycle must be dropped
        wr(4'd4, 32'h7);
        wb.in_is_dj   = 1'b1;
        wb.in_djtaken = 1'b1;
        wb.in_target  = 24'h001234;
        tick();
        wr(4'd9, 32'hDEAD);
        #1;
        check("dj_redir", 32'(wb.redirect_valid), 32'd1);
        check("dj_pc", 32'(wb.redirect_pc), 32'h001234);
        check("dj_ready", 32'(wb.in_ready), 32'd0);
        check("dj_wr_a", 32'(wb.rf_waddr), 32'd4);
        tick();
        idle();
        check("dj_pulse_end", 32'(wb.redirect_valid), 32'd0);
        check("dj_squashed", 32'(wb.rf_we), 32'd0);
        wr(4'd4, 32'h6);
        wb.in_is_dj  = 1'b1;
        wb.in_target = 24'h005678;
        tick();
        idle();
        check("djnt_redir", 32'(wb.redirect_valid), 32'd0);
        check("djnt_wr", 32'(wb.rf_wdata), 32'h6);
        tick();

        // CMP 5-5: flags only, no push
        wb.rf_ready = 1'b0;
        wr(4'd10, 32'h33);
        tick();
        idle();
        wb.in_valid    = 1'b1;
        wb.in_cout     = 1'b1;
        wb.in_flags_we = 1'b1;
        tick();
        idle();
        check("cmp_psr", 32'(psr()), 32'b1010);
        check("cmp_head_a", 32'(wb.rf_waddr), 32'd10);
        check("cmp_ready", 32'(wb.in_ready), 32'd1);
        wb.rf_ready = 1'b1;
        tick();
        check("cmp_no_push", 32'(wb.rf_we), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
